uart_rx: RTL and testbench

- Asynchronous serial receiver; the receive-side counterpart of the team's uart_tx.
- Frame format: 8N1, idle-high line, LSB-first.
- Samples the serial line at mid-bit using a baud counter derived from the system clock.
- Delivers each received byte as a one-cycle valid pulse to the downstream consumer; flags frames with a bad stop bit.

---
 rtl/uart_rx_if.sv | 17 +
 rtl/uart_rx.sv | 162 ++++++++++++++++
 tb/tb_uart_rx.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_if.sv
// uart_rx_if: serial line plus the parallel receive outputs of uart_rx.
//   rx        : asynchronous serial line, idle high
//   rx_data   : last received byte
//   rx_valid  : one-cycle pulse, rx_data is new and the frame was good
//   frame_err : one-cycle pulse, stop bit sampled low
//   busy      : receiver is inside a frame (or waiting out a break)
// master = the receiver, slave = the line driver / byte consumer.
interface uart_rx_if;
  logic       rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (input rx, output rx_data, rx_valid, frame_err, busy);
  modport slave  (output rx, input rx_data, rx_valid, frame_err, busy);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: 8N1 asynchronous serial receiver, LSB first, idle-high line.
// The line is synchronised, the start edge is qualified at mid start bit,
// then each data bit and the stop bit are sampled one bit time apart.
// Ports:
//   clk : system clock, rising edge
//   rst : synchronous active-high reset
//   bus : uart_rx_if.master (rx in; rx_data, rx_valid, frame_err, busy out)
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes a
// 2-of-3 vote over the last three synchronised samples, decided at the same
// cycle as the single-sample version so timing does not change.
module uart_rx #(
  parameter int BAUD_RATE   = 115_200,
  parameter int CLOCK_SPEED = 50_000_000,
  parameter int BAUD_WIDTH  = int'(CLOCK_SPEED / BAUD_RATE),
  parameter int HALF_WIDTH  = BAUD_WIDTH / 2
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  localparam int CW = $clog2(BAUD_WIDTH);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_WIDTH - 1);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_WIDTH - 1);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    START = 5'b00010,
    DATA  = 5'b00100,
    STOP  = 5'b01000,
    BREAK = 5'b10000
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [2:0]    idx, idx_nxt;
  logic [7:0]    shreg, shreg_nxt;
  logic [7:0]    data_q, data_nxt;
  logic          valid_q, valid_nxt;
  logic          err_q, err_nxt;
  logic          rx_meta, rx_s;
  logic          bit_val;

  // Two-flop synchroniser; both flops reset to the idle level so reset
  // never looks like a start edge.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples the pre-edge value of its neighbours.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= bus.rx;
      rx_s    <= rx_meta;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // hist holds rx_s from the two previous cycles, so at the nominal sample
  // point the vote spans cnt==S-2, S-1 and S.
  logic [1:0] hist;
  always_ff @(posedge clk) begin
    if (rst) hist <= 2'b11;
    else     hist <= {hist[0], rx_s};
  end
  assign bit_val = (hist[1] & hist[0]) | (hist[1] & rx_s) | (hist[0] & rx_s);
`else
  assign bit_val = rx_s;
`endif

  // NOTE: every output of this block gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    idx_nxt   = idx;
    shreg_nxt = shreg;
    data_nxt  = data_q;
    valid_nxt = 1'b0;
    err_nxt   = 1'b0;
    unique case (state)
      IDLE: begin
        if (!rx_s) begin
          state_nxt = START;
          cnt_nxt   = '0;
        end
      end
      START: begin
        if (cnt == HALF_LAST) begin
          cnt_nxt   = '0;
          idx_nxt   = '0;
          // A line that is high again by mid start bit was only a glitch.
          state_nxt = bit_val ? IDLE : DATA;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      DATA: begin
        if (cnt == BAUD_LAST) begin
          // Right shift: after eight bits the first one received is bit 0.
          shreg_nxt = {bit_val, shreg[7:1]};
          cnt_nxt   = '0;
          idx_nxt   = idx + 3'd1;
          if (idx == 3'd7) state_nxt = STOP;
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      STOP: begin
        if (cnt == BAUD_LAST) begin
          cnt_nxt = '0;
          if (bit_val) begin
            data_nxt  = shreg;
            valid_nxt = 1'b1;
            state_nxt = IDLE;
          end else begin
            err_nxt   = 1'b1;
            state_nxt = BREAK;
          end
        end else begin
          cnt_nxt = cnt + CW'(1);
        end
      end
      BREAK: begin
        // Wait for the line to return high so a held-low line never
        // masquerades as a new start bit.
        if (rx_s) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      idx     <= '0;
      data_q  <= 8'h00;
      valid_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      idx     <= idx_nxt;
      data_q  <= data_nxt;
      valid_q <= valid_nxt;
      err_q   <= err_nxt;
    end
  end

  // NOTE: the shift register is left out of reset on purpose: all eight
  // bits are rewritten by a frame before it is ever copied to rx_data.
  always_ff @(posedge clk) begin
    shreg <= shreg_nxt;
  end

  assign bus.rx_data   = data_q;
  assign bus.rx_valid  = valid_q;
  assign bus.frame_err = err_q;
  assign bus.busy      = (state != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx at 16 clocks per bit.
// Each driven frame pushes its expected outcome (good byte, or frame error
// with rx_data unchanged); a negedge monitor pops and compares on every
// rx_valid / frame_err pulse.
module tb_uart_rx;
  localparam int CLOCK_SPEED = 16;
  localparam int BAUD_RATE   = 1;
  localparam int BW          = 16;
  localparam int HW          = 8;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  uart_rx_if bus ();

  uart_rx #(
    .BAUD_RATE  (BAUD_RATE),
    .CLOCK_SPEED(CLOCK_SPEED)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  exp_t       sb[$];
  int         n_checks   = 0;
  int         n_fail     = 0;
  int         cyc        = 0;
  int         n_pulses   = 0;
  int         last_pulse = -1;
  int         prev_pulse = -1;
  int         frame_start = 0;
  logic [7:0] model_data = 8'h00;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin : monitor
    exp_t e;
    if (bus.rx_valid || bus.frame_err) begin
      check("pulse_exclusive", 32'(bus.rx_valid & bus.frame_err), 32'd0);
      if (sb.size() == 0) begin
        check("unexpected_pulse", 32'({bus.rx_valid, bus.frame_err}), 32'd0);
      end else begin
        e = sb.pop_front();
        check("pulse_kind", 32'(bus.frame_err), 32'(e.err));
        check("pulse_data", 32'(bus.rx_data), 32'(e.data));
      end
      n_pulses++;
      prev_pulse = last_pulse;
      last_pulse = cyc;
    end
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input logic glitch);
    logic [9:0] bits;
    bits = {stop, d, 1'b0};
    if (stop) begin
      sb.push_back(exp_t'{err: 1'b0, data: d});
      model_data = d;
    end else begin
      sb.push_back(exp_t'{err: 1'b1, data: model_data});
    end
    frame_start = cyc;
    for (int b = 0; b < 10; b++) begin
      for (int c = 0; c < BW; c++) begin
        bus.rx = (glitch && b >= 1 && b <= 8 && c == HW) ? ~bits[b] : bits[b];
        @(negedge clk);
      end
    end
    bus.rx = 1'b1;
  endtask

  task automatic wait_drain(input string tag);
    int k;
    k = 0;
    while (sb.size() != 0 && k < 400) begin
      @(negedge clk);
      k++;
    end
    check({tag, "_drain"}, 32'(sb.size()), 32'd0);
    sb.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_data = 8'h00;
    sb.delete();
  endtask

  initial begin : watchdog
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int pulses_before;
    logic [9:0] bits;

    bus.rx = 1'b1;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;

    // Idle after reset: all outputs at reset values.
    for (int i = 0; i < 50; i++) begin
      check("reset_idle", 32'({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy}), 32'd0);
      @(negedge clk);
    end

    // Single frame with latency check.
    send_frame(8'hA5, 1'b1, 1'b0);
    wait_drain("a5");
    check("a5_latency", 32'(last_pulse - frame_start), 32'd155);
    check("a5_hold", 32'(bus.rx_data), 32'hA5);
    repeat (10) @(negedge clk);

    // Back-to-back frames with no idle gap.
    send_frame(8'h00, 1'b1, 1'b0);
    send_frame(8'hFF, 1'b1, 1'b0);
    wait_drain("b2b");
    check("b2b_spacing", 32'(last_pulse - prev_pulse), 32'd160);
    check("b2b_data", 32'(bus.rx_data), 32'hFF);
    repeat (10) @(negedge clk);

    // Short low glitch is rejected at the start-bit sample.
    pulses_before = n_pulses;
    bus.rx = 1'b0;
    repeat (4) @(negedge clk);
    check("glitch_busy_high", 32'(bus.busy), 32'd1);
    bus.rx = 1'b1;
    repeat (20) @(negedge clk);
    check("glitch_busy_low", 32'(bus.busy), 32'd0);
    check("glitch_no_pulse", 32'(n_pulses - pulses_before), 32'd0);
    check("glitch_data_hold", 32'(bus.rx_data), 32'hFF);

    // Bad stop bit, held-low break, then a good frame.
    do_reset();
    repeat (5) @(negedge clk);
    send_frame(8'h3C, 1'b0, 1'b0);
    bus.rx = 1'b0;
    repeat (40) @(negedge clk);
    wait_drain("break_err");
    check("err_latency", 32'(last_pulse - frame_start), 32'd155);
    check("break_busy", 32'(bus.busy), 32'd1);
    check("break_data", 32'(bus.rx_data), 32'h00);
    bus.rx = 1'b1;
    repeat (8) @(negedge clk);
    check("break_exit_busy", 32'(bus.busy), 32'd0);
    send_frame(8'h81, 1'b1, 1'b0);
    wait_drain("after_break");
    check("after_break_data", 32'(bus.rx_data), 32'h81);
    repeat (10) @(negedge clk);

    // Reset in the middle of data bit 4; the frame is dropped.
    pulses_before = n_pulses;
    bits = {1'b1, 8'hE7, 1'b0};
    for (int b = 0; b < 5; b++) begin
      for (int c = 0; c < BW; c++) begin
        if (b == 4 && c == HW) break;
        bus.rx = bits[b];
        @(negedge clk);
      end
    end
    check("midrst_busy_before", 32'(bus.busy), 32'd1);
    rst = 1'b1;
    bus.rx = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_data = 8'h00;
    check("midrst_outputs", 32'({bus.rx_data, bus.rx_valid, bus.frame_err, bus.busy}), 32'd0);
    repeat (200) @(negedge clk);
    check("midrst_no_pulse", 32'(n_pulses - pulses_before), 32'd0);
    check("midrst_data", 32'(bus.rx_data), 32'h00);
    send_frame(8'h5A, 1'b1, 1'b0);
    wait_drain("after_rst");
    check("after_rst_data", 32'(bus.rx_data), 32'h5A);

`ifdef UART_RX_MAJORITY_EN
    // Single-cycle inverted glitch at every data sample point.
    repeat (10) @(negedge clk);
    send_frame(8'hC3, 1'b1, 1'b1);
    wait_drain("majority");
    check("majority_data", 32'(bus.rx_data), 32'hC3);
`endif

    repeat (10) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
